// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit. Tracks destination tags of the DEPTH
// stages downstream of ID and picks the youngest forwarding source per operand.

module fwd_src_sel #(
  parameter int DEPTH      = 3,
  parameter int REG_AW     = 5,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(DEPTH+1)
) (
  input  logic [REG_AW-1:0]             rs,
  input  logic                          rs_live,
  input  logic [DEPTH:1]                ent_v,
  input  logic [DEPTH:1][REG_AW-1:0]    ent_rd,
  input  logic [DEPTH:1]                ent_ld,
  output logic [SEL_W-1:0]              sel,
  output logic                          load_wait
);
  // Scan oldest to youngest so the youngest match overwrites; no fallback.
  always_comb begin
    sel       = '0;
    load_wait = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (rs_live && ent_v[k] && (ent_rd[k] != '0) && (ent_rd[k] == rs)) begin
        sel       = SEL_W'(k);
        load_wait = ent_ld[k] && (k < LOAD_READY);
      end
    end
  end
endmodule

module fwd_hazard_unit #(
  parameter int DEPTH      = 3,
  parameter int REG_AW     = 5,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              hold,
  input  logic              flush,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  stall_cycles
);
  logic [DEPTH:1]             vld_pipe;
  logic [DEPTH:1][REG_AW-1:0] rd_pipe;
  logic [DEPTH:1]             ld_pipe;

  logic [1:0][REG_AW-1:0] op_rs;
  logic [1:0]             op_live;
  logic [1:0][SEL_W-1:0]  op_sel;
  logic [1:0]             op_wait;

  assign op_rs   = {id_rs2, id_rs1};
  assign op_live = {id_valid && id_rs2_used, id_valid && id_rs1_used};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_op
      fwd_src_sel #(
        .DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)
      ) u_sel (
        .rs(op_rs[g]), .rs_live(op_live[g]),
        .ent_v(vld_pipe), .ent_rd(rd_pipe), .ent_ld(ld_pipe),
        .sel(op_sel[g]), .load_wait(op_wait[g])
      );
    end
  endgenerate

  assign fwd_a        = op_sel[0];
  assign fwd_b        = op_sel[1];
  assign hazard_stall = |op_wait;

  // hold freezes everything, including a pending flush, until it drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe     <= '0;
      rd_pipe      <= '0;
      ld_pipe      <= '0;
      stall_cycles <= '0;
    end else if (!hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        vld_pipe[k] <= vld_pipe[k-1];
        rd_pipe[k]  <= rd_pipe[k-1];
        ld_pipe[k]  <= ld_pipe[k-1];
      end
      vld_pipe[1] <= id_valid && id_regwrite && !hazard_stall && !flush;
      rd_pipe[1]  <= id_rd;
      ld_pipe[1]  <= id_is_load;
      if (hazard_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: instance a (LOAD_READY=2, 16-bit counter)
// and instance b (LOAD_READY=3, 2-bit counter) share one stimulus stream.

module tb_fwd_hazard_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       hold, flush;

  logic [1:0]  a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b;
  logic        a_stall, b_stall;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .hold(hold), .flush(flush),
    .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .hazard_stall(a_stall), .stall_cycles(a_cnt)
  );

  fwd_hazard_unit #(.DEPTH(3), .LOAD_READY(3), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .hold(hold), .flush(flush),
    .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .hazard_stall(b_stall), .stall_cycles(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2,
                          input logic [4:0] rd, input logic rw, input logic ld);
    id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_rd = rd; id_regwrite = rw; id_is_load = ld;
    #1;
  endtask

  task automatic drain;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_fwd_a", a_fwd_a, 0);
    chk("rst_fwd_b", a_fwd_b, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_cnt",   a_cnt, 0);
    rst_n = 1'b1;
    #1;

    // ALU chain: add x5; sub x6,x5,x1; or x7,x5,x0
    drive_id(1, 1, 1, 2, 1, 5, 1, 0);
    chk("t1_empty", a_fwd_a, 0);
    tick;
    drive_id(1, 5, 1, 1, 1, 6, 1, 0);
    chk("t1_fwd_a1", a_fwd_a, 1);
    chk("t1_fwd_b0", a_fwd_b, 0);
    chk("t1_stall",  a_stall, 0);
    tick;
    drive_id(1, 5, 1, 0, 1, 7, 1, 0);
    chk("t1_fwd_a2", a_fwd_a, 2);
    chk("t1_fwd_b_x0", a_fwd_b, 0);
    drain;
    chk("t1_drained", a_fwd_a, 0);

    // Priority: x7 written in stages 1 and 2
    drive_id(1, 1, 1, 2, 1, 7, 1, 0);
    tick;
    drive_id(1, 0, 1, 0, 0, 7, 1, 0);
    tick;
    drive_id(1, 3, 1, 7, 1, 8, 1, 0);
    chk("t2_fwd_b", a_fwd_b, 1);
    chk("t2_fwd_a", a_fwd_a, 0);
    drain;

    // Load-use: lw x3; add x4,x3,x3
    drive_id(1, 1, 1, 0, 0, 3, 1, 1);
    tick;
    drive_id(1, 3, 1, 3, 1, 4, 1, 0);
    chk("t3_a_stall1", a_stall, 1);
    chk("t3_a_fa1",    a_fwd_a, 1);
    chk("t3_a_fb1",    a_fwd_b, 1);
    chk("t3_b_stall1", b_stall, 1);
    tick;
    chk("t3_a_stall2", a_stall, 0);
    chk("t3_a_fa2",    a_fwd_a, 2);
    chk("t3_a_fb2",    a_fwd_b, 2);
    chk("t3_a_cnt",    a_cnt, 1);
    chk("t3_b_stall2", b_stall, 1);
    chk("t3_b_fa2",    b_fwd_a, 2);
    chk("t3_b_cnt1",   b_cnt, 1);
    tick;
    chk("t3_b_stall3", b_stall, 0);
    chk("t3_b_fa3",    b_fwd_a, 3);
    chk("t3_b_cnt2",   b_cnt, 2);
    chk("t3_a_fa3",    a_fwd_a, 3);
    chk("t3_a_cnt_hd", a_cnt, 1);
    drain;

    // x0 destination, unused operand, invalid ID, no regwrite
    drive_id(1, 1, 1, 2, 1, 0, 1, 0);
    tick;
    drive_id(1, 0, 1, 0, 1, 8, 1, 0);
    chk("t4_x0_a", a_fwd_a, 0);
    chk("t4_x0_b", a_fwd_b, 0);
    chk("t4_x0_st", a_stall, 0);
    tick;
    drive_id(1, 8, 0, 8, 1, 9, 0, 0);
    chk("t4_unused_a", a_fwd_a, 0);
    chk("t4_used_b",   a_fwd_b, 1);
    tick;
    drive_id(0, 8, 1, 8, 1, 0, 0, 0);
    chk("t4_invalid_a", a_fwd_a, 0);
    drive_id(1, 9, 1, 8, 1, 0, 0, 0);
    chk("t4_norw_a", a_fwd_a, 0);
    chk("t4_norw_b", a_fwd_b, 2);
    drain;

    // Hold with load in stage 1, flush asserted during hold and at release
    drive_id(1, 1, 1, 0, 0, 10, 1, 1);
    tick;
    drive_id(1, 10, 1, 0, 0, 11, 1, 0);
    hold = 1'b1; flush = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t5_hold_stall", a_stall, 1);
      chk("t5_hold_fa",    a_fwd_a, 1);
      chk("t5_hold_cnt",   a_cnt, 1);
    end
    chk("t5_hold_bcnt", b_cnt, 2);
    hold = 1'b0;
    tick;
    flush = 1'b0;
    drive_id(1, 11, 1, 10, 1, 0, 0, 0);
    chk("t5_no_rd11",  a_fwd_a, 0);
    chk("t5_fb_ld",    a_fwd_b, 2);
    chk("t5_a_stall",  a_stall, 0);
    chk("t5_b_stall",  b_stall, 1);
    chk("t5_a_cnt",    a_cnt, 2);
    chk("t5_b_cnt",    b_cnt, 3);
    drain;
    drive_id(1, 1, 1, 0, 0, 12, 1, 0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    drive_id(1, 12, 1, 0, 0, 0, 0, 0);
    chk("t5_flush_fa", a_fwd_a, 0);
    drain;

    // Reset mid-operation
    drive_id(1, 0, 0, 0, 0, 13, 1, 0);
    tick;
    drive_id(1, 0, 0, 0, 0, 14, 1, 0);
    tick;
    drive_id(1, 0, 0, 0, 0, 15, 1, 1);
    tick;
    drive_id(1, 13, 1, 15, 1, 0, 0, 0);
    chk("t6_pre_fa", a_fwd_a, 3);
    chk("t6_pre_fb", a_fwd_b, 1);
    chk("t6_pre_st", a_stall, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_fa",   a_fwd_a, 0);
    chk("t6_rst_fb",   a_fwd_b, 0);
    chk("t6_rst_st",   a_stall, 0);
    chk("t6_rst_cnt",  a_cnt, 0);
    chk("t6_rst_bcnt", b_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_post_fa", a_fwd_a, 0);
    chk("t6_post_fb", a_fwd_b, 0);

    // Saturation on the 2-bit counter: load chain lw x3 <- x3
    drive_id(1, 1, 1, 0, 0, 3, 1, 1);
    tick;
    drive_id(1, 3, 1, 0, 0, 3, 1, 1);
    repeat (4) tick;
    chk("t6_b_cnt_e5", b_cnt, 3);
    repeat (2) tick;
    chk("t6_b_stall_pre", b_stall, 1);
    tick;
    chk("t6_b_sat", b_cnt, 3);
    chk("t6_a_cnt", a_cnt, 4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
